// File: rtl/uart_cmd_parser.sv
// ASCII debug command decoder (a / wAD..D / rA) producing register strobes and an ASCII reply stream.
// Strobe 1 cycle after the terminator, reply 1 (write) or 2 (read) cycles later; input stalls while a reply drains.
module uart_cmd_parser #(
  parameter int DATA_DIGITS = 8,
  parameter int TIMEOUT     = 600000,
  localparam int DW         = 4 * DATA_DIGITS
) (
  input  logic          clock,
  input  logic          areset_n,
  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic [7:0]    s_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic [7:0]    m_tdata,
  output logic          dump_o,
  output logic          wr_stb_o,
  output logic          rd_stb_o,
  output logic [3:0]    addr_o,
  output logic [DW-1:0] wdata_o,
  input  logic [DW-1:0] rd_data_i,
  output logic          timeout_o
);

  localparam int IW = $clog2(DATA_DIGITS + 3) + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_TERM    = 3'd3;
  localparam logic [2:0] S_EXEC    = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;
  localparam logic [2:0] S_DISCARD = 3'd6;

  localparam logic [1:0] R_WR  = 2'd0;
  localparam logic [1:0] R_RD  = 2'd1;
  localparam logic [1:0] R_ERR = 2'd2;

  logic [2:0]    state;
  logic          op_rd;
  logic [DW-1:0] dsh;
  logic [IW-1:0] dcnt;
  logic [1:0]    resp_kind;
  logic [DW-1:0] resp_word;
  logic [IW-1:0] idx;
  logic          rd_pend;
  logic [TW-1:0] tcnt;

  logic          is_term, is_dig, is_hex;
  logic [3:0]    hex_val;
  logic          counting, acc, to_fire;
  logic [IW-1:0] ndig;
  logic [3:0]    nib;
  logic [7:0]    hex_chr, resp_byte;

  assign is_term  = (s_tdata == 8'h0D) || (s_tdata == 8'h0A);
  assign is_dig   = (s_tdata >= 8'h30) && (s_tdata <= 8'h39);
  assign is_hex   = is_dig || ((s_tdata >= 8'h41) && (s_tdata <= 8'h46))
                           || ((s_tdata >= 8'h61) && (s_tdata <= 8'h66));
  assign hex_val  = is_dig ? s_tdata[3:0] : s_tdata[3:0] + 4'd9;

  assign counting = (state == S_ADDR) || (state == S_DATA) || (state == S_TERM) || (state == S_DISCARD);
  assign s_tready = areset_n && ((state == S_IDLE) || counting);
  assign acc      = s_tvalid && s_tready;
  // An accepted byte always wins over a timeout landing on the same cycle.
  assign to_fire  = (TIMEOUT > 0) && counting && !acc && (tcnt == TW'(TIMEOUT - 1));

  assign wr_stb_o = (state == S_EXEC) && !op_rd;
  assign rd_stb_o = (state == S_EXEC) && op_rd;

  // Read replies shift the captured word so the next digit is always the top nibble.
  assign ndig     = (resp_kind == R_RD) ? IW'(DATA_DIGITS) : IW'(1);
  assign nib      = resp_word[DW-1 -: 4];
  assign hex_chr  = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  assign m_tvalid = (state == S_RESP) && !rd_pend;
  assign m_tlast  = m_tvalid && (idx == ndig + IW'(1));
  assign m_tdata  = m_tvalid ? resp_byte : 8'h00;

  always_comb begin
    resp_byte = 8'h0A;
    if (idx < ndig) begin
      case (resp_kind)
        R_RD:    resp_byte = hex_chr;
        R_WR:    resp_byte = 8'h4B;
        default: resp_byte = 8'h3F;
      endcase
    end else if (idx == ndig) begin
      resp_byte = 8'h0D;
    end
  end

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      state     <= S_IDLE;
      op_rd     <= 1'b0;
      dsh       <= '0;
      dcnt      <= '0;
      resp_kind <= R_WR;
      resp_word <= '0;
      idx       <= '0;
      rd_pend   <= 1'b0;
      tcnt      <= '0;
      addr_o    <= '0;
      wdata_o   <= '0;
      dump_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      dump_o    <= 1'b0;
      timeout_o <= 1'b0;

      if (!counting || acc || to_fire) tcnt <= '0;
      else if (TIMEOUT > 0)            tcnt <= tcnt + 1'b1;

      if (to_fire) begin
        state     <= S_IDLE;
        timeout_o <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (acc) begin
            if (s_tdata == 8'h61) begin
              dump_o <= 1'b1;
            end else if ((s_tdata == 8'h77) || (s_tdata == 8'h72)) begin
              op_rd <= (s_tdata == 8'h72);
              dsh   <= '0;
              dcnt  <= '0;
              state <= S_ADDR;
            end else if (!is_term) begin
              state <= S_DISCARD;
            end
          end
          S_ADDR: if (acc) begin
            if (is_hex) begin
              addr_o <= hex_val;
              state  <= op_rd ? S_TERM : S_DATA;
            end else if (is_term) begin
              resp_kind <= R_ERR;
              idx       <= '0;
              rd_pend   <= 1'b0;
              state     <= S_RESP;
            end else begin
              state <= S_DISCARD;
            end
          end
          S_DATA: if (acc) begin
            if (is_hex) begin
              dsh  <= (dsh << 4) | DW'(hex_val);
              dcnt <= dcnt + 1'b1;
              if (dcnt == IW'(DATA_DIGITS - 1)) state <= S_TERM;
            end else if (is_term) begin
              resp_kind <= R_ERR;
              idx       <= '0;
              rd_pend   <= 1'b0;
              state     <= S_RESP;
            end else begin
              state <= S_DISCARD;
            end
          end
          S_TERM: if (acc) begin
            if (is_term) begin
              if (!op_rd) wdata_o <= dsh;
              state <= S_EXEC;
            end else begin
              state <= S_DISCARD;
            end
          end
          S_DISCARD: if (acc && is_term) begin
            resp_kind <= R_ERR;
            idx       <= '0;
            rd_pend   <= 1'b0;
            state     <= S_RESP;
          end
          S_EXEC: begin
            resp_kind <= op_rd ? R_RD : R_WR;
            idx       <= '0;
            rd_pend   <= op_rd;
            state     <= S_RESP;
          end
          S_RESP: begin
            if (rd_pend) begin
              resp_word <= rd_data_i;
              rd_pend   <= 1'b0;
            end else if (m_tready) begin
              if (m_tlast) begin
                state <= S_IDLE;
              end else begin
                idx       <= idx + 1'b1;
                resp_word <= resp_word << 4;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized and directed bench for uart_cmd_parser against a string-level command model.
module tb_uart_cmd_parser;
  localparam int DD = 8;
  localparam int DW = 32;
  localparam int TO = 100;

  typedef logic [7:0] bq_t [$];

  logic          clock = 1'b0;
  logic          areset_n;
  logic          s_tvalid, s_tready;
  logic [7:0]    s_tdata;
  logic          m_tvalid, m_tready, m_tlast;
  logic [7:0]    m_tdata;
  logic          dump_o, wr_stb_o, rd_stb_o, timeout_o;
  logic [3:0]    addr_o;
  logic [DW-1:0] wdata_o, rd_data_i;

  always #5 clock = ~clock;

  uart_cmd_parser #(.DATA_DIGITS(DD), .TIMEOUT(TO)) dut (
    .clock(clock), .areset_n(areset_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tdata(m_tdata),
    .dump_o(dump_o), .wr_stb_o(wr_stb_o), .rd_stb_o(rd_stb_o),
    .addr_o(addr_o), .wdata_o(wdata_o), .rd_data_i(rd_data_i), .timeout_o(timeout_o)
  );

  int n_chk = 0, n_fail = 0;
  int n_dump = 0, n_to = 0, n_wr = 0, n_rd = 0, n_rx = 0, exp_dump = 0;
  int rdy_mode = 0;
  logic [8:0]  exp_bytes [$];
  logic [37:0] exp_stb [$];
  logic [7:0]  rx_log [$];
  logic        prev_stall = 1'b0;
  logic [8:0]  prev_b, mon_b;
  logic [37:0] mon_s;
  logic [7:0]  nh [6] = '{8'h5A, 8'h67, 8'h20, 8'h78, 8'h2D, 8'h47};
  logic [7:0]  junk [6] = '{8'h71, 8'h5A, 8'h3F, 8'h31, 8'h20, 8'h62};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait budget expired at %0t", name, $time);
  endtask

  function automatic int hexv(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  // Command-level model: kind 0 dump, 1 write, 2 read, 3 error.
  function automatic void model(input bq_t c, output int kind, output logic [3:0] a, output logic [31:0] d);
    int n;
    bit ok;
    n = c.size();
    kind = 3; a = 4'h0; d = 32'h0;
    if (n == 1 && c[0] == "a") begin
      kind = 0;
    end else if ((c[0] == "w" && n == DD + 3) || (c[0] == "r" && n == 3)) begin
      ok = 1'b1;
      for (int i = 1; i <= n - 2; i++) if (hexv(c[i]) < 0) ok = 1'b0;
      if (ok) begin
        kind = (c[0] == "w") ? 1 : 2;
        a = 4'(hexv(c[1]));
        for (int i = 2; i <= n - 2; i++) d = d * 16 + 32'(hexv(c[i]));
      end
    end
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic logic [7:0] rhex();
    int v;
    v = $urandom_range(0, 15);
    if (v < 10) return 8'(48 + v);
    return 8'(($urandom_range(0, 1) != 0 ? 55 : 87) + v);
  endfunction

  function automatic bq_t gen(input int cat);
    bq_t q;
    int k;
    case (cat)
      0: q.push_back("a");
      1: begin q.push_back("w"); q.push_back(rhex()); for (int i = 0; i < DD; i++) q.push_back(rhex()); end
      2: begin q.push_back("r"); q.push_back(rhex()); end
      3: begin q.push_back("w"); q.push_back(rhex()); k = $urandom_range(0, DD - 1);
               for (int i = 0; i < k; i++) q.push_back(rhex()); end
      4: begin q.push_back("r"); q.push_back(rhex()); q.push_back(rhex()); end
      5: begin q.push_back(($urandom_range(0, 1) != 0) ? 8'h77 : 8'h72); q.push_back(nh[$urandom_range(0, 5)]); end
      default: begin q.push_back(junk[$urandom_range(0, 5)]); k = $urandom_range(0, 3);
               for (int i = 0; i < k; i++) q.push_back(8'($urandom_range(32, 126))); end
    endcase
    if (cat != 0) q.push_back(($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A);
    return q;
  endfunction

  task automatic expect_cmd(input int kind, input logic [3:0] a, input logic [31:0] d, input logic [31:0] rdv);
    int nib;
    case (kind)
      0: exp_dump++;
      1: begin exp_stb.push_back({1'b0, a, 1'b0, d});
               exp_bytes.push_back({1'b0, 8'h4B}); exp_bytes.push_back({1'b0, 8'h0D}); exp_bytes.push_back({1'b1, 8'h0A}); end
      2: begin exp_stb.push_back({1'b1, a, 33'h0});
               for (int i = 0; i < DD; i++) begin
                 nib = int'((rdv >> (4 * (DD - 1 - i))) % 16);
                 exp_bytes.push_back({1'b0, 8'((nib < 10) ? 48 + nib : 55 + nib)});
               end
               exp_bytes.push_back({1'b0, 8'h0D}); exp_bytes.push_back({1'b1, 8'h0A}); end
      default: begin exp_bytes.push_back({1'b0, 8'h3F}); exp_bytes.push_back({1'b0, 8'h0D}); exp_bytes.push_back({1'b1, 8'h0A}); end
    endcase
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    repeat ($urandom_range(0, 2)) @(negedge clock);
    @(negedge clock);
    s_tvalid = 1'b1;
    s_tdata  = b;
    k = 0;
    while (!s_tready && k < 5000) begin @(negedge clock); k++; end
    if (k >= 5000) begin fail_now("send_byte"); s_tvalid = 1'b0; return; end
    @(posedge clock);
    #1 s_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_bytes.size() != 0 || exp_stb.size() != 0 || m_tvalid) && k < 4000) begin @(negedge clock); k++; end
    if (k >= 4000) fail_now("drain");
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_rx(input int target);
    int k;
    k = 0;
    while (n_rx < target && k < 2000) begin @(negedge clock); k++; end
    if (k >= 2000) fail_now("wait_rx");
  endtask

  task automatic run_cmd(input bq_t c, input bit extra_lf, input logic [31:0] rdv);
    int kind;
    logic [3:0] a;
    logic [31:0] d;
    model(c, kind, a, d);
    rd_data_i = rdv;
    expect_cmd(kind, a, d, rdv);
    foreach (c[i]) send_byte(c[i]);
    if (extra_lf) send_byte(8'h0A);
    wait_drain();
  endtask

  task automatic check_dump(input string name);
    send_byte("a");
    exp_dump++;
    @(negedge clock);
    chk({name, "_pulse"}, dump_o, 1'b1);
    chk({name, "_no_resp"}, m_tvalid, 1'b0);
    @(negedge clock);
    chk({name, "_single"}, dump_o, 1'b0);
  endtask

  // m_tready pattern: 0 always, 1 toggle, 2 random, 3 held low.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        0: m_tready = 1'b1;
        1: m_tready = !m_tready;
        2: m_tready = ($urandom_range(0, 1) != 0);
        default: m_tready = 1'b0;
      endcase
    end
  end

  always @(negedge clock) begin
    if (!areset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_b});
      if (m_tvalid) chk("resp_blocks_input", s_tready, 1'b0);
      if (m_tvalid && m_tready) begin
        if (exp_bytes.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_byte: got %0h expected none", m_tdata);
        end else begin
          mon_b = exp_bytes.pop_front();
          chk("resp_byte", {m_tlast, m_tdata}, mon_b);
        end
        rx_log.push_back(m_tdata);
        n_rx++;
      end
      if (wr_stb_o || rd_stb_o) begin
        chk("strobe_vs_tvalid", {wr_stb_o & rd_stb_o, m_tvalid}, 2'b00);
        if (exp_stb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_strobe: got wr=%0b rd=%0b expected none", wr_stb_o, rd_stb_o);
        end else begin
          mon_s = exp_stb.pop_front();
          chk("strobe_type", rd_stb_o, mon_s[37]);
          chk("strobe_addr", addr_o, mon_s[36:33]);
          if (!mon_s[37]) chk("strobe_wdata", wdata_o, mon_s[31:0]);
        end
        if (wr_stb_o) n_wr++;
        if (rd_stb_o) n_rd++;
      end
      if (dump_o) n_dump++;
      if (timeout_o) n_to++;
      prev_stall = m_tvalid && !m_tready;
      prev_b     = {m_tlast, m_tdata};
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t q, lit;
    int kind, b, wb, rb, t0, first;
    logic [3:0] a;
    logic [31:0] d;

    areset_n = 1'b0; s_tvalid = 1'b0; s_tdata = 8'h00; rd_data_i = '0;
    #1;
    chk("reset_outputs", {s_tready, m_tvalid, m_tlast, m_tdata, dump_o, wr_stb_o, rd_stb_o, addr_o, wdata_o, timeout_o}, 64'h0);
    repeat (3) @(negedge clock);
    areset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_reset", s_tready, 1'b1);

    q = str2q("w3DEADBEEF"); q.push_back(8'h0D);
    model(q, kind, a, d);
    chk("model_w_kind", kind, 1); chk("model_w_addr", a, 4'h3); chk("model_w_data", d, 32'hDEADBEEF);
    q = str2q("r5"); q.push_back(8'h0D);
    model(q, kind, a, d);
    chk("model_r_kind", kind, 2); chk("model_r_addr", a, 4'h5);
    q = str2q("w1123"); q.push_back(8'h0D);
    model(q, kind, a, d);
    chk("model_short_kind", kind, 3);

    check_dump("dump");

    b = rx_log.size(); wb = n_wr;
    q = str2q("w3DEADBEEF"); q.push_back(8'h0D);
    run_cmd(q, 1'b1, 32'h0);
    chk("wr_one_strobe", n_wr - wb, 1);
    chk("wr_addr_hold", addr_o, 4'h3);
    chk("wr_data_hold", wdata_o, 32'hDEADBEEF);
    chk("wr_resp_len", rx_log.size() - b, 3);
    if (rx_log.size() - b == 3) chk("wr_resp_bytes", {rx_log[b], rx_log[b+1], rx_log[b+2]}, 24'h4B0D0A);

    rdy_mode = 1;
    b = rx_log.size(); rb = n_rd;
    q = str2q("r5"); q.push_back(8'h0D);
    run_cmd(q, 1'b1, 32'h0000ABCD);
    chk("rd_one_strobe", n_rd - rb, 1);
    chk("rd_addr", addr_o, 4'h5);
    chk("rd_resp_len", rx_log.size() - b, 10);
    lit = str2q("0000ABCD"); lit.push_back(8'h0D); lit.push_back(8'h0A);
    if (rx_log.size() - b == 10) foreach (lit[i]) chk("rd_resp_char", rx_log[b+i], lit[i]);

    // Long stall in the middle of a read reply.
    q = str2q("r9"); q.push_back(8'h0D);
    model(q, kind, a, d);
    rd_data_i = $urandom;
    expect_cmd(kind, a, d, rd_data_i);
    b = n_rx;
    foreach (q[i]) send_byte(q[i]);
    wait_rx(b + 4);
    rdy_mode = 3;
    repeat (20) begin
      @(negedge clock);
      chk("stall_tvalid", {m_tvalid, s_tready}, 2'b10);
    end
    rdy_mode = 1;
    wait_drain();
    chk("stall_resp_len", n_rx - b, 10);

    rdy_mode = 0;
    wb = n_wr; rb = n_rd;
    q = str2q("wZ");    q.push_back(8'h0D); run_cmd(q, 1'b0, 32'h0);
    q = str2q("w1123"); q.push_back(8'h0D); run_cmd(q, 1'b0, 32'h0);
    q = str2q("r12");   q.push_back(8'h0D); run_cmd(q, 1'b0, 32'h0);
    q = str2q("q");     q.push_back(8'h0A); run_cmd(q, 1'b0, 32'h0);
    chk("err_no_strobes", {n_wr - wb, n_rd - rb}, 64'h0);
    b = rx_log.size();
    if (b >= 3) chk("err_resp_bytes", {rx_log[b-3], rx_log[b-2], rx_log[b-1]}, 24'h3F0D0A);

    t0 = n_to; b = n_rx; first = 0;
    foreach (lit[i]) lit.delete(i);
    q = str2q("w7AB");
    foreach (q[i]) send_byte(q[i]);
    for (int k = 1; k <= 150; k++) begin
      @(negedge clock);
      if (timeout_o && first == 0) first = k;
    end
    chk("timeout_once", n_to - t0, 1);
    chk("timeout_when", (first >= TO && first <= TO + 2), 1'b1);
    chk("timeout_no_resp", n_rx - b, 0);
    chk("timeout_addr_kept", addr_o, 4'h7);
    check_dump("dump_after_timeout");

    rdy_mode = 1;
    q = str2q("r2"); q.push_back(8'h0D);
    model(q, kind, a, d);
    rd_data_i = 32'h12345678;
    expect_cmd(kind, a, d, rd_data_i);
    b = n_rx;
    foreach (q[i]) send_byte(q[i]);
    wait_rx(b + 3);
    @(posedge clock);
    #2 areset_n = 1'b0;
    #1;
    chk("reset_mid_resp", {s_tready, m_tvalid, m_tlast, m_tdata, dump_o, wr_stb_o, rd_stb_o, addr_o, wdata_o, timeout_o}, 64'h0);
    exp_bytes.delete();
    exp_stb.delete();
    rdy_mode = 0;
    repeat (3) @(negedge clock);
    areset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_rst2", s_tready, 1'b1);
    b = n_rx;
    check_dump("dump_after_reset");
    repeat (10) @(negedge clock);
    chk("no_stale_bytes", n_rx - b, 0);

    for (int it = 0; it < 40; it++) begin
      rdy_mode = $urandom_range(0, 2);
      q = gen($urandom_range(0, 6));
      run_cmd(q, ($urandom_range(0, 1) != 0), $urandom);
    end
    rdy_mode = 0;
    wait_drain();

    chk("dump_total", n_dump, exp_dump);
    chk("timeout_total", n_to, 1);
    chk("queues_empty", {exp_bytes.size() != 0, exp_stb.size() != 0}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Consumes the byte stream from the UART receiver (AXI4-Stream, 8b) and decodes single-line ASCII commands for bench and board debug: dump trigger, register write, register read.
- Produces register strobes and a dump-start pulse, plus an ASCII response stream that feeds the UART transmitter's input.
- Sits between the UART and the telemetry/hex-dump logic, replacing the ad-hoc `'a'` byte compare in the top level.

Parameters:
- DATA_DIGITS, 8, number of hex digits in a write/read data word; data width DW = 4*DATA_DIGITS.
- TIMEOUT, 600000, idle cycles (10 ms at 60 MHz) before a partial command is abandoned; 0 disables the timeout.

Ports:
- clock  in  1  system clock (60 MHz).
- areset_n  in  1  asynchronous, active-low reset.
- s_tvalid  in  1  RX byte valid (from UART).
- s_tready  out  1  RX byte accept.
- s_tdata  in  8  RX byte.
- m_tvalid  out  1  response byte valid (to UART TX).
- m_tready  in  1  response byte accept.
- m_tlast  out  1  high on the final byte (LF) of each response.
- m_tdata  out  8  response byte.
- dump_o  out  1  one-cycle pulse: start telemetry dump.
- wr_stb_o  out  1  one-cycle register-write strobe.
- rd_stb_o  out  1  one-cycle register-read strobe.
- addr_o  out  4  register address.
- wdata_o  out  DW  write data.
- rd_data_i  in  DW  read data, sampled on the cycle after rd_stb_o.
- timeout_o  out  1  one-cycle pulse when a partial command is abandoned.

Behaviour:
- Reset is asynchronous on areset_n low. While in reset: all outputs are 0, state is IDLE, and any in-flight response is dropped. s_tready is 0 during reset and 1 after reset in the input states.
- Command grammar:
  - `a`: dump request.
  - `w` + 1 hex addr + DATA_DIGITS hex data + terminator: write.
  - `r` + 1 hex addr + terminator: read.
  - Terminator is CR or LF.
  - Hex digits are 0-9, A-F, a-f.
- States: IDLE, ADDR, DATA, TERM, EXEC, RESP, DISCARD.
- s_tready = 1 in IDLE, ADDR, DATA, TERM and DISCARD; 0 in EXEC and RESP. Input is back-pressured while a response drains.
- IDLE transitions:
  - `a` → dump_o pulses on the next cycle; no response; stay in IDLE.
  - `w` or `r` → ADDR, with the operation latched.
  - CR/LF → ignored, so CRLF line endings are harmless.
  - Any other byte → DISCARD.
- ADDR: a hex digit is latched into addr_o, then go to DATA (write) or TERM (read). A non-hex byte goes to DISCARD; a CR/LF as the non-hex byte goes directly to RESP with the error response.
- DATA: data is shifted in MSB-first (shift left by 4, OR in the digit). After exactly DATA_DIGITS digits, go to TERM. An early terminator or a non-hex byte is an error, handled exactly as in ADDR.
- TERM: CR/LF goes to EXEC. Any other byte (extra digits, spaces) goes to DISCARD.
- DISCARD: consume bytes until CR/LF, then go to RESP with the error response.
- EXEC (1 cycle after the terminator is accepted):
  - Write: wr_stb_o = 1, with addr_o/wdata_o valid. The response is `K` CR LF.
  - Read: rd_stb_o = 1. rd_data_i is captured on the next cycle, then the response is DATA_DIGITS uppercase hex chars (MSB first) + CR LF.
  - addr_o and wdata_o hold their values until the next command updates them.
- RESP:
  - Bytes are emitted under AXIS rules: m_tdata/m_tlast are stable while m_tvalid=1 and m_tready=0.
  - Bytes advance only on m_tvalid & m_tready.
  - m_tlast = 1 on LF only.
  - After LF is accepted, return to IDLE.
- Error response: `?` CR LF (3 bytes). No strobe is issued.
- Timeout:
  - The counter clears on every accepted byte and counts only in ADDR, DATA, TERM and DISCARD.
  - When it reaches TIMEOUT: return to IDLE, pulse timeout_o, send no response, leave addr_o/wdata_o unchanged.
  - TIMEOUT=0 disables the counter.
- Simultaneous events: a byte accepted on the same cycle the timeout would fire takes priority (the counter clears). Strobes never coincide with m_tvalid's first byte; the first response byte appears no earlier than 1 cycle (write) or 2 cycles (read) after EXEC.
- At most one strobe or dump pulse is issued per command; strobes never repeat while back-pressured.

Test Plan:
- Bytes `a` → exactly one dump_o pulse on the cycle after acceptance; m_tvalid stays 0.
- `w3DEADBEEF` CR → one wr_stb_o pulse with addr_o=3, wdata_o=32'hDEADBEEF. Response 0x4B,0x0D,0x0A with m_tlast only on 0x0A. A trailing LF is then ignored.
- `r5` CR LF with rd_data_i=32'h0000ABCD → one rd_stb_o pulse, addr_o=5. Response is `0000ABCD` CR LF (10 bytes) and the extra LF produces no second response.
- Error inputs → `?` CR LF, and no strobes:
  - `wZ` CR;
  - `w1123` CR (short data);
  - `r12` CR (extra digit);
  - `q` LF.
- Response back-pressure: m_tready toggled every other cycle, then held low for 20 cycles mid-response → no byte lost, duplicated or changed while stalled; s_tready=0 throughout.
- Timeout (TIMEOUT=100): send `w7AB` then idle 100 cycles → timeout_o pulses once, state returns to IDLE, no response. A following `a` → dump_o.
- Reset mid-response: assert areset_n low during byte 4 of a read response → outputs are 0 immediately. After release, `a` works normally and no stale response bytes appear.
